// File: rtl/spike_rate_decoder.sv
// Spike-train to rate decoder: counts spikes over a window of enabled cycles and hands each count
// out through a one-entry valid/ready register. Define SPIKE_DECODER_ISI_EN for inter-spike intervals.
module spike_rate_decoder #(
  parameter int unsigned COUNT_W = 8,
  parameter int unsigned WIN_W   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               spike_in,
  input  logic [WIN_W-1:0]   window_len,
  output logic [COUNT_W-1:0] out_count,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               overflow
`ifdef SPIKE_DECODER_ISI_EN
  ,
  output logic [WIN_W-1:0]   isi_out,
  output logic               isi_valid
`endif
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  localparam logic [COUNT_W-1:0] COUNT_MAX = {COUNT_W{1'b1}};

  logic [0:0]         state_q;
  logic [WIN_W-1:0]   len_q;
  logic [WIN_W-1:0]   win_cnt_q;
  logic [COUNT_W-1:0] spk_cnt_q;
  logic [COUNT_W-1:0] out_count_q;
  logic               out_valid_q;
  logic               overflow_q;

  logic [WIN_W-1:0]   cur_len;
  logic [WIN_W-1:0]   cur_cnt;
  logic [COUNT_W-1:0] cur_spk;
  logic [WIN_W:0]     win_next;
  logic [WIN_W:0]     len_ext;
  logic [COUNT_W-1:0] spk_sum;
  logic               win_done;
  logic               load;

  // IDLE behaves like the first cycle of a fresh window using the live window_len.
  always_comb begin
    cur_len  = (state_q == IDLE) ? window_len : len_q;
    cur_cnt  = (state_q == IDLE) ? '0 : win_cnt_q;
    cur_spk  = (state_q == IDLE) ? '0 : spk_cnt_q;
    win_next = {1'b0, cur_cnt} + {{WIN_W{1'b0}}, 1'b1};
    len_ext  = {(cur_len == '0), cur_len};
    spk_sum  = (cur_spk == COUNT_MAX) ? cur_spk : cur_spk + COUNT_W'(spike_in);
    win_done = enable && (win_next == len_ext);
    load     = win_done && (!out_valid_q || out_ready);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      len_q       <= '0;
      win_cnt_q   <= '0;
      spk_cnt_q   <= '0;
      out_count_q <= '0;
      out_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      if (enable) begin
        state_q <= RUN;
        if (win_done) begin
          len_q     <= window_len;
          win_cnt_q <= '0;
          spk_cnt_q <= '0;
        end else begin
          len_q     <= cur_len;
          win_cnt_q <= win_next[WIN_W-1:0];
          spk_cnt_q <= spk_sum;
        end
      end
      if (load) begin
        out_count_q <= spk_sum;
        out_valid_q <= 1'b1;
      end else if (out_valid_q && out_ready) begin
        out_valid_q <= 1'b0;
      end
      if (win_done && !load) begin
        overflow_q <= 1'b1;
      end
    end
  end

  assign out_count = out_count_q;
  assign out_valid = out_valid_q;
  assign overflow  = overflow_q;

`ifdef SPIKE_DECODER_ISI_EN
  localparam logic [WIN_W-1:0] ISI_MAX = {WIN_W{1'b1}};

  logic [WIN_W-1:0] isi_cnt_q;
  logic [WIN_W-1:0] isi_out_q;
  logic             isi_armed_q;
  logic             isi_valid_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      isi_cnt_q   <= '0;
      isi_out_q   <= '0;
      isi_armed_q <= 1'b0;
      isi_valid_q <= 1'b0;
    end else begin
      isi_valid_q <= 1'b0;
      if (enable && spike_in) begin
        if (isi_armed_q) begin
          isi_out_q   <= (isi_cnt_q == ISI_MAX) ? ISI_MAX : isi_cnt_q + 1'b1;
          isi_valid_q <= 1'b1;
        end
        isi_armed_q <= 1'b1;
        isi_cnt_q   <= '0;
      end else if (enable && isi_cnt_q != ISI_MAX) begin
        isi_cnt_q <= isi_cnt_q + 1'b1;
      end
    end
  end

  assign isi_out   = isi_out_q;
  assign isi_valid = isi_valid_q;
`endif

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Directed bench for spike_rate_decoder: default 8-bit build plus a 2-bit-count instance for
// saturation. ISI checks compile only when SPIKE_DECODER_ISI_EN is defined.
module tb_spike_rate_decoder;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       spike_in = 1'b0;
  logic       out_ready = 1'b0;
  logic [7:0] window_len = 8'd0;
  logic [7:0] out_count;
  logic       out_valid;
  logic       overflow;
  logic [1:0] out_count_s;
  logic       out_valid_s;
  logic       overflow_s;
`ifdef SPIKE_DECODER_ISI_EN
  logic [7:0] isi_out;
  logic       isi_valid;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  spike_rate_decoder #(.COUNT_W(8), .WIN_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .spike_in   (spike_in),
    .window_len (window_len),
    .out_count  (out_count),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .overflow   (overflow)
`ifdef SPIKE_DECODER_ISI_EN
    ,
    .isi_out    (isi_out),
    .isi_valid  (isi_valid)
`endif
  );

  spike_rate_decoder #(.COUNT_W(2), .WIN_W(8)) dut_sat (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .spike_in   (spike_in),
    .window_len (window_len),
    .out_count  (out_count_s),
    .out_valid  (out_valid_s),
    .out_ready  (out_ready),
    .overflow   (overflow_s)
`ifdef SPIKE_DECODER_ISI_EN
    ,
    .isi_out    (),
    .isi_valid  ()
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    enable   = 1'b0;
    spike_in = 1'b0;
    step();
    reset    = 1'b0;
  endtask

  initial begin
    // 1: basic window of 10 with spikes on 2,5,9; window_len change mid-window deferred
    do_reset();
    check_eq("rst_valid", 32'(out_valid), 32'd0);
    check_eq("rst_count", 32'(out_count), 32'd0);
    check_eq("rst_ovf", 32'(overflow), 32'd0);
    window_len = 8'd10;
    enable     = 1'b1;
    out_ready  = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      spike_in = (c == 2 || c == 5 || c == 9);
      if (c == 5) window_len = 8'd3;
      step();
      if (c < 10) check_eq("t1_early_valid", 32'(out_valid), 32'd0);
    end
    check_eq("t1_valid", 32'(out_valid), 32'd1);
    check_eq("t1_count", 32'(out_count), 32'd3);
    for (int c = 1; c <= 3; c++) begin
      spike_in = (c == 2);
      step();
      if (c == 1) check_eq("t1_xfer_clear", 32'(out_valid), 32'd0);
    end
    check_eq("t1_w2_valid", 32'(out_valid), 32'd1);
    check_eq("t1_w2_count", 32'(out_count), 32'd1);

    // 2: continuous spikes, 4-cycle windows; 2-bit instance saturates at 3
    do_reset();
    window_len = 8'd4;
    enable     = 1'b1;
    spike_in   = 1'b1;
    out_ready  = 1'b1;
    for (int w = 0; w < 2; w++) begin
      repeat (4) step();
      check_eq("t2_valid", 32'(out_valid), 32'd1);
      check_eq("t2_count", 32'(out_count), 32'd4);
      check_eq("t2_sat_valid", 32'(out_valid_s), 32'd1);
      check_eq("t2_sat_count", 32'(out_count_s), 32'd3);
    end
    check_eq("t2_sat_ovf", 32'(overflow_s), 32'd0);

    // 3: backpressure for two windows drops the second and sets sticky overflow
    do_reset();
    window_len = 8'd5;
    out_ready  = 1'b0;
    enable     = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      spike_in = (c <= 2);
      step();
      if (c == 5) begin
        check_eq("t3_w1_valid", 32'(out_valid), 32'd1);
        check_eq("t3_w1_count", 32'(out_count), 32'd2);
        check_eq("t3_w1_ovf", 32'(overflow), 32'd0);
      end
    end
    check_eq("t3_w2_valid", 32'(out_valid), 32'd1);
    check_eq("t3_w2_count", 32'(out_count), 32'd2);
    check_eq("t3_w2_ovf", 32'(overflow), 32'd1);
    enable    = 1'b0;
    spike_in  = 1'b0;
    out_ready = 1'b1;
    step();
    check_eq("t3_xfer_valid", 32'(out_valid), 32'd0);
    check_eq("t3_xfer_ovf", 32'(overflow), 32'd1);
    step();
    check_eq("t3_ovf_sticky", 32'(overflow), 32'd1);
    do_reset();
    check_eq("t3_ovf_reset", 32'(overflow), 32'd0);

    // 4: enable toggling halves the rate; 6 enabled cycles take 12 clocks
    window_len = 8'd6;
    spike_in   = 1'b1;
    out_ready  = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      enable = (c % 2 == 0);
      step();
      if (c == 11) check_eq("t4_early_valid", 32'(out_valid), 32'd0);
    end
    check_eq("t4_valid", 32'(out_valid), 32'd1);
    check_eq("t4_count", 32'(out_count), 32'd6);

    // 5: window_len=0 means 256 cycles; reset mid-window discards the partial count
    do_reset();
    window_len = 8'd0;
    enable     = 1'b1;
    out_ready  = 1'b1;
    for (int c = 1; c <= 256; c++) begin
      spike_in = (c % 16 == 1);
      step();
      if (c == 255) check_eq("t5_early_valid", 32'(out_valid), 32'd0);
    end
    check_eq("t5_valid", 32'(out_valid), 32'd1);
    check_eq("t5_count", 32'(out_count), 32'd16);
    for (int c = 1; c <= 100; c++) begin
      spike_in = (c % 16 == 1);
      step();
    end
    reset = 1'b1;
    step();
    check_eq("t5_rst_valid", 32'(out_valid), 32'd0);
    check_eq("t5_rst_count", 32'(out_count), 32'd0);
    check_eq("t5_rst_ovf", 32'(overflow), 32'd0);
    reset      = 1'b0;
    window_len = 8'd3;
    spike_in   = 1'b0;
    enable     = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      step();
      if (c == 2) check_eq("t5_post_early", 32'(out_valid), 32'd0);
    end
    check_eq("t5_post_valid", 32'(out_valid), 32'd1);
    check_eq("t5_post_count", 32'(out_count), 32'd0);

`ifdef SPIKE_DECODER_ISI_EN
    // 6: inter-spike intervals for spikes at enabled cycles 3, 10, 14
    do_reset();
    window_len = 8'd0;
    enable     = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      spike_in = (c == 3 || c == 10 || c == 14);
      step();
      check_eq("t6_isi_valid", 32'(isi_valid), 32'(c == 10 || c == 14));
      if (c == 10) check_eq("t6_isi_7", 32'(isi_out), 32'd7);
      if (c == 14) check_eq("t6_isi_4", 32'(isi_out), 32'd4);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spike_rate_decoder.md
Name: spike_rate_decoder

Overview:
Receiving end of the neuron spike interface: converts a single-bit spike train (as produced by the LIF neuron's spike_out) back into a multi-bit rate value.
- Counts spikes over a programmable window of enabled clock cycles.
- Presents each window's count on a valid/ready output with a one-entry holding register.
- Sits downstream of neuron instances, feeding readout logic or the next layer's input current.

Parameters:
COUNT_W, 8, width of spike count and of out_count; count saturates at 2^COUNT_W-1
WIN_W, 8, width of window_len and internal window counter

Ports:
clk  input  1  clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
enable  input  1  advance window/count only when high
spike_in  input  1  spike pulse; each high cycle counts as one spike
window_len  input  WIN_W  window length in enabled cycles; 0 means 2^WIN_W
out_count  output  COUNT_W  spike count of the last completed window
out_valid  output  1  out_count holds an unconsumed result
out_ready  input  1  consumer accepts result when out_valid && out_ready
overflow  output  1  sticky: a completed window was dropped

Behaviour:
- Reset, sampled on the clk edge: state=IDLE; window counter, spike counter, out_count=0; out_valid=0; overflow=0. Reset mid-window discards the partial count and any held result.
- IDLE: on the first cycle with enable=1, latch window_len into len_q, window counter=1, spike counter=spike_in, go to RUN.
- RUN, enable=1 and window counter != len_q (mod 2^WIN_W): window counter+1; spike counter += spike_in, saturating at 2^COUNT_W-1.
- RUN, enable=1 and window counter == len_q (last cycle): final = saturating spike counter + spike_in.
  - Result goes to the output register; out_valid=1 on the next cycle, so latency is 1 cycle after the last window cycle.
  - Same cycle: restart the window. Re-latch window_len, window counter=0 then next enabled cycle is 1, spike counter=0.
  - This cycle's spike belongs to the closing window.
- len_q=0 gives a 2^WIN_W-cycle window; the comparison is performed at WIN_W+1 bits.
- enable=0: window and spike counters hold; spike_in ignored; output handshake still operates.
- window_len changes mid-window take effect only at the next window start.
- Output handshake:
  - out_count is stable while out_valid=1.
  - Transfer occurs on a cycle with out_valid && out_ready; out_valid clears next cycle unless a new result loads the same cycle.
  - out_ready with out_valid=0 has no effect.
- Window completion with register empty or transferring this cycle: load new result, out_valid=1.
- Window completion with out_valid=1 and out_ready=0: drop the new result; keep the old one; set overflow=1.
- overflow stays set until reset.

Optional Feature:
Macro SPIKE_DECODER_ISI_EN adds inter-spike-interval measurement.
- Extra ports: isi_out output WIN_W, isi_valid output 1 (single-cycle pulse).
- A free-running interval counter counts enabled cycles since the last spike and saturates at 2^WIN_W-1.
- On each spike after the first since reset: isi_out=counter+1 and isi_valid pulses the following cycle; the counter then clears.
- The first spike after reset only arms the counter.
- Without the macro: no extra ports or logic; behaviour otherwise identical.

Test Plan:
1. Reset, window_len=10, enable=1, spike_in high on cycles 2,5,9 of window, out_ready=1 -> out_valid pulses 1 cycle after cycle 10 with out_count=3; the next window starts immediately.
2. window_len=4, spike_in held high continuously, COUNT_W=2 -> every window reports out_count=3, saturated rather than wrapped (full 8-bit build: 4).
3. window_len=5, out_ready=0 for two full windows -> first count held stable with out_valid=1; second window dropped; overflow=1. Raise out_ready -> first count transferred; overflow stays 1 until reset.
4. window_len=6, enable toggled 1/0 each cycle with spike_in=1 on all cycles -> window closes after 12 cycles; out_count=6.
5. window_len=0 (WIN_W=8), one spike per 16 cycles -> window lasts 256 cycles; out_count=16. Assert reset at cycle 100 of a window -> all outputs 0 next cycle; state IDLE.
6. SPIKE_DECODER_ISI_EN defined, spikes at enabled cycles 3, 10, 14 -> isi_valid pulses twice, isi_out=7 then 4; no pulse for the first spike.
